qpsk_tx_ctrl: RTL
=================

// Module: qpsk_tx_ctrl
// PURPOSE
//  Frame sequencer for the QPSK modulator. Accepts a frame request (byte count) and a
//  byte stream over valid/ready, then drives the modulator's serial input x MSB-first:
//  preamble, then payload, then tail. One bit is held for BIT_DIV clocks.
//  Also gates the modulator (mod_en) and reports busy/done/underrun.
// PARAMETERS
//  BIT_DIV    4         clocks per serial bit (>=2)
//  PRE_LEN    16        preamble length in bits (1..32)
//  PRE_PAT    32'hCCCC  preamble pattern; bits [PRE_LEN-1:0] sent MSB-first
//  TAIL_BITS  2         zero bits appended after payload (even, >=0)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  synchronous reset, active low
//  start       in   1  frame request pulse, sampled in IDLE only
//  len         in   8  payload byte count, sampled with start
//  s_data      in   8  payload byte
//  s_valid     in   1  s_data valid
//  s_ready     out  1  controller can accept a byte this cycle
//  x           out  1  serial bit to QPSK modulator input
//  bit_strobe  out  1  one-cycle pulse on the first clock of every bit period
//  mod_en      out  1  high while a frame is on x (modulator enable)
//  busy        out  1  high from accepted start until return to IDLE
//  done        out  1  one-cycle pulse on return to IDLE
//  err         out  1  one-cycle pulse on payload underrun
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): state=IDLE. x, bit_strobe, mod_en, busy, done, err,
//   s_ready = 0. Holding register is emptied and the bit counters are cleared.
//   This applies mid-frame as well: the frame is dropped and done is not pulsed.
//  States: IDLE -> PRE -> DATA -> TAIL -> IDLE.
//  IDLE: x=0 and mod_en=0.
//   - start=1 with len!=0 at edge T: latch len; state=PRE; from T+1, busy=mod_en=1.
//   - start with len==0 is ignored. start in any other state is ignored.
//  Bit timing: a divider counts 0..BIT_DIV-1 from state entry. x changes only when the
//   divider is 0, and bit_strobe=1 in that same cycle. Each bit is held exactly BIT_DIV clks.
//  PRE: sends PRE_PAT[PRE_LEN-1] down to PRE_PAT[0], then enters DATA.
//  Holding register (1 byte): s_ready = (state!=IDLE) && hold empty.
//   - A transfer occurs when s_valid && s_ready; it fills hold.
//   - Prefetch during PRE is allowed.
//   - s_ready is never high in IDLE or TAIL, and never after all len bytes are accepted.
//  DATA: at each byte boundary (first data bit and every 8th bit thereafter), the shift
//   register loads from hold and hold empties in that cycle. s_ready may be 1 on the next clk.
//   - After 8*len bits, enter TAIL.
//   - Underrun: hold empty at a byte boundary -> err=1 for one cycle, enter TAIL at once,
//     and x=0 from that cycle on.
//  TAIL: sends TAIL_BITS zeros, then goes to IDLE with done=1 for one cycle.
//   - busy and mod_en drop in that same cycle. TAIL_BITS=0 skips straight to IDLE.
//  Frame length, no underrun: (PRE_LEN + 8*len + TAIL_BITS)*BIT_DIV clks of busy=1.
//  Simultaneous start and done: start is ignored. Back-to-back frames need start at the
//   earliest one cycle after done.
//  Counters: byte counter 8 bits, bit index 3 bits, preamble index $clog2(PRE_LEN+1) bits;
//   no wrap is possible within legal parameters.
// TESTING
//  1 Reset: hold rst=0 for 3 clks with start=1, s_valid=1 -> all outputs 0, state IDLE.
//  2 Defaults. start with len=1, s_data=8'hA5 valid from T+1:
//    -> x = CCCC bits (1100..) then 10100101 then 00, each held 4 clks.
//    -> busy high 104 clks, done pulse on clk 105, err=0, 26 bit_strobe pulses.
//  3 len=3 with s_valid held high and bytes 11,22,33:
//    -> contiguous payload, no gap; exactly 3 transfers; s_ready low after the 3rd.
//  4 Underrun. len=2, supply only 8'hFF:
//    -> 8 ones, then err pulse at the 2nd byte boundary, then x=0 for 2 bits.
//    -> done pulses, busy total (16+8+2)*4 clks.
//  5 start with len=0 -> no busy. start pulsed mid-frame -> ignored, frame length unchanged.
//  6 rst=0 for 1 clk during DATA -> next clk all outputs 0, no done.
//    A new start then runs a normal frame.

Source files
------------

// File: rtl/qpsk_tx_ctrl.sv
// Frame sequencer for the QPSK modulator: preamble, payload bytes MSB-first, zero tail,
// one serial bit per BIT_DIV clocks, fed from a one-byte holding register.
module qpsk_tx_ctrl #(
   parameter int          BIT_DIV   = 4,
   parameter int          PRE_LEN   = 16,
   parameter logic [31:0] PRE_PAT   = 32'hCCCC,
   parameter int          TAIL_BITS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] len,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic       x,
   output logic       bit_strobe,
   output logic       mod_en,
   output logic       busy,
   output logic       done,
   output logic       err
);
   localparam int DW = $clog2(BIT_DIV);
   localparam int PW = $clog2(PRE_LEN + 1);
   localparam int TW = $clog2(TAIL_BITS + 2);

   typedef enum logic [1:0] {IDLE, PRE, DATA, TAIL} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [PW-1:0] pre_idx_q, pre_idx_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [TW-1:0] tail_idx_q, tail_idx_d;
   logic [7:0]    len_q, len_d, acc_cnt_q, acc_cnt_d, byte_cnt_q, byte_cnt_d;
   logic [7:0]    hold_q, hold_d, shreg_q, shreg_d;
   logic          hold_vld_q, hold_vld_d, done_q, done_d, err_q, err_d;
   logic          div_last, xfer, boundary, hold_nxt, leave_data, underrun;
   logic [4:0]    pre_sel;

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      pre_idx_d  = pre_idx_q;
      bit_idx_d  = bit_idx_q;
      tail_idx_d = tail_idx_q;
      len_d      = len_q;
      acc_cnt_d  = acc_cnt_q;
      byte_cnt_d = byte_cnt_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      shreg_d    = shreg_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      x          = 1'b0;
      leave_data = 1'b0;
      underrun   = 1'b0;

      div_last = (div_q == DW'(BIT_DIV - 1));
      boundary = (state_q == DATA) && (div_q == '0) && (bit_idx_q == 3'd0);
      s_ready  = ((state_q == PRE) || (state_q == DATA)) && !hold_vld_q && (acc_cnt_q != len_q);
      xfer     = s_valid && s_ready;
      // Hold state as it will be at the upcoming byte boundary; underrun is resolved one
      // clock early so the error cycle is already the first TAIL cycle.
      hold_nxt = hold_vld_q || xfer;
      pre_sel  = 5'(PRE_LEN - 1) - 5'(pre_idx_q);

      if (xfer) begin
         hold_d     = s_data;
         hold_vld_d = 1'b1;
         acc_cnt_d  = acc_cnt_q + 8'd1;
      end
      if (boundary) begin
         shreg_d    = hold_q;
         hold_vld_d = 1'b0;
         byte_cnt_d = byte_cnt_q + 8'd1;
      end
      div_d = div_last ? '0 : div_q + DW'(1);

      case (state_q)
         IDLE: begin
            div_d = '0;
            if (start && (len != 8'd0) && !done_q) begin
               state_d    = PRE;
               len_d      = len;
               acc_cnt_d  = 8'd0;
               byte_cnt_d = 8'd0;
               pre_idx_d  = '0;
               bit_idx_d  = 3'd0;
               hold_vld_d = 1'b0;
            end
         end
         PRE: begin
            x = PRE_PAT[pre_sel];
            if (div_last) begin
               pre_idx_d = pre_idx_q + PW'(1);
               if (pre_idx_q == PW'(PRE_LEN - 1)) begin
                  if (hold_nxt) begin
                     state_d = DATA;
                     div_d   = '0;
                  end else begin
                     underrun = 1'b1;
                  end
               end
            end
         end
         DATA: begin
            x = boundary ? hold_q[7] : shreg_q[3'd7 - bit_idx_q];
            if (div_last) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  if (byte_cnt_q == len_q) leave_data = 1'b1;
                  else if (!hold_nxt)      underrun   = 1'b1;
               end
            end
         end
         TAIL: begin
            if (div_last) begin
               tail_idx_d = tail_idx_q + TW'(1);
               if (tail_idx_q == TW'(TAIL_BITS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (leave_data || underrun) begin
         err_d      = underrun;
         div_d      = '0;
         tail_idx_d = '0;
         if (TAIL_BITS == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = TAIL;
         end
      end

      busy       = (state_q != IDLE);
      mod_en     = busy;
      bit_strobe = busy && (div_q == '0);
      done       = done_q;
      err        = err_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         div_q      <= '0;
         pre_idx_q  <= '0;
         bit_idx_q  <= 3'd0;
         tail_idx_q <= '0;
         len_q      <= 8'd0;
         acc_cnt_q  <= 8'd0;
         byte_cnt_q <= 8'd0;
         hold_q     <= 8'd0;
         hold_vld_q <= 1'b0;
         shreg_q    <= 8'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         pre_idx_q  <= pre_idx_d;
         bit_idx_q  <= bit_idx_d;
         tail_idx_q <= tail_idx_d;
         len_q      <= len_d;
         acc_cnt_q  <= acc_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         shreg_q    <= shreg_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end
endmodule
